// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage hazard inputs and the forward/stall/flush
// controls exchanged between the pipeline datapath and hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int FWD_W  = 2
);
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic [REG_AW-1:0] WriteRegD;
    logic              RegWriteD;
    logic              MemToRegD;
    logic              BranchD;
    logic              PCSrcD;
    logic              mem_busyM;
    logic [FWD_W-1:0]  forwardAE;
    logic [FWD_W-1:0]  forwardBE;
    logic              forwardAD;
    logic              forwardBD;
    logic              stallF;
    logic              stallD;
    logic              flushD;
    logic              stallE;
    logic              flushE;
    logic              stallM;
    logic              flushW;

    modport master (
        output rsD, rtD, WriteRegD, RegWriteD, MemToRegD,
        output BranchD, PCSrcD, mem_busyM,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
        input  stallF, stallD, flushD, stallE, flushE, stallM, flushW
    );

    modport slave (
        input  rsD, rtD, WriteRegD, RegWriteD, MemToRegD,
        input  BranchD, PCSrcD, mem_busyM,
        output forwardAE, forwardBE, forwardAD, forwardBD,
        output stallF, stallD, flushD, stallE, flushE, stallM, flushW
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch stalls and memory waits for the
// 5-stage MIPS core. Define HAZARD_PERF_CNT_EN to add saturating stall counters.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int FWD_W  = 2
) (
    input  logic         CLK,
    input  logic         RST,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]  lw_stall_cnt,
    output logic [31:0]  br_stall_cnt,
    output logic [31:0]  mem_wait_cnt
`endif
);

    localparam logic [FWD_W-1:0] SEL_RF  = FWD_W'(0);
    localparam logic [FWD_W-1:0] SEL_WB  = FWD_W'(1);
    localparam logic [FWD_W-1:0] SEL_MEM = FWD_W'(2);

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wreg;
        logic              regwrite;
        logic              memtoreg;
        logic              branch;
        logic              valid;
    } stg_t;

    stg_t e_q, e_d, m_q, m_d, w_q, w_d;
    logic rdy_q;

    logic wr_e, wr_m, wr_w;
    logic lwstall, brstall, memwait, ld_stall, any_stall;
    logic [FWD_W-1:0] fae, fbe;

    assign wr_e = e_q.valid & e_q.regwrite & (e_q.wreg != '0);
    assign wr_m = m_q.valid & m_q.regwrite & (m_q.wreg != '0);
    assign wr_w = w_q.valid & w_q.regwrite & (w_q.wreg != '0);

    always_comb begin
        fae = SEL_RF;
        fbe = SEL_RF;
        if (wr_m && e_q.rs == m_q.wreg)      fae = SEL_MEM;
        else if (wr_w && e_q.rs == w_q.wreg) fae = SEL_WB;
        if (wr_m && e_q.rt == m_q.wreg)      fbe = SEL_MEM;
        else if (wr_w && e_q.rt == w_q.wreg) fbe = SEL_WB;
    end

    assign lwstall = e_q.valid & e_q.memtoreg & (e_q.wreg != '0)
                   & ((e_q.wreg == hz.rsD) | (e_q.wreg == hz.rtD));
    assign brstall = hz.BranchD & (
                       (wr_e & ((e_q.wreg == hz.rsD) | (e_q.wreg == hz.rtD)))
                     | (wr_m & m_q.memtoreg
                        & ((m_q.wreg == hz.rsD) | (m_q.wreg == hz.rtD))));
    assign memwait   = hz.mem_busyM & m_q.valid;
    assign ld_stall  = (lwstall | brstall) & ~memwait;
    assign any_stall = memwait | ld_stall;

    // rdy_q keeps every output low during reset and the first cycle after it
    assign hz.forwardAE = rdy_q ? fae : SEL_RF;
    assign hz.forwardBE = rdy_q ? fbe : SEL_RF;
    assign hz.forwardAD = rdy_q & wr_m & (hz.rsD == m_q.wreg);
    assign hz.forwardBD = rdy_q & wr_m & (hz.rtD == m_q.wreg);
    assign hz.stallF    = rdy_q & any_stall;
    assign hz.stallD    = rdy_q & any_stall;
    assign hz.flushD    = rdy_q & hz.PCSrcD & ~any_stall;
    assign hz.stallE    = rdy_q & memwait;
    assign hz.flushE    = rdy_q & ld_stall;
    assign hz.stallM    = rdy_q & memwait;
    assign hz.flushW    = rdy_q & memwait;

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (memwait) begin
            w_d = '0;
        end else if (ld_stall) begin
            e_d = '0;
            m_d = e_q;
            w_d = m_q;
        end else begin
            e_d.rs       = hz.rsD;
            e_d.rt       = hz.rtD;
            e_d.wreg     = hz.WriteRegD;
            e_d.regwrite = hz.RegWriteD;
            e_d.memtoreg = hz.MemToRegD;
            e_d.branch   = hz.BranchD;
            e_d.valid    = 1'b1;
            m_d = e_q;
            w_d = m_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            rdy_q <= 1'b0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            rdy_q <= 1'b1;
        end
    end

    logic unused;
    assign unused = ^{e_q.branch, m_q.rs, m_q.rt, m_q.branch,
                      w_q.rs, w_q.rt, w_q.memtoreg, w_q.branch};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lw_q, br_q, mw_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lw_q <= '0;
            br_q <= '0;
            mw_q <= '0;
        end else begin
            if (lwstall && !memwait && lw_q != '1) lw_q <= lw_q + 32'd1;
            if (brstall && !memwait && br_q != '1) br_q <= br_q + 32'd1;
            if (memwait && mw_q != '1)             mw_q <= mw_q + 32'd1;
        end
    end

    assign lw_stall_cnt = lw_q;
    assign br_stall_cnt = br_q;
    assign mem_wait_cnt = mw_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, flushes and reset
// behaviour of hazard_ctrl.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hazard_ctrl_if #(.REG_AW(5), .FWD_W(2)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lw_cnt, br_cnt, mw_cnt;
`endif

    hazard_ctrl #(.REG_AW(5), .FWD_W(2)) dut (
        .CLK (clk),
        .RST (rst),
        .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .lw_stall_cnt (lw_cnt),
        .br_stall_cnt (br_cnt),
        .mem_wait_cnt (mw_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {fAE[1:0], fBE[1:0], fAD, fBD, stallF, stallD, flushD, stallE, flushE, stallM, flushW}
    function automatic logic [12:0] ov();
        return {hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD,
                hz.stallF, hz.stallD, hz.flushD, hz.stallE, hz.flushE,
                hz.stallM, hz.flushW};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic rw,
                       input logic mtr, input logic br,
                       input logic pc, input logic busy);
        hz.rsD       = rs;
        hz.rtD       = rt;
        hz.WriteRegD = wr;
        hz.RegWriteD = rw;
        hz.MemToRegD = mtr;
        hz.BranchD   = br;
        hz.PCSrcD    = pc;
        hz.mem_busyM = busy;
        #1;
    endtask

    localparam logic [6:0] LDSTALL = 7'b1100100;
    localparam logic [6:0] MWAIT   = 7'b1101011;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 1, 0);

        // reset and the first cycle after release keep outputs low
        cyc();
        chk("rst_hold", 32'(ov()), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_first", 32'(ov()), 32'h0);
        cyc();
        chk("flushD_free", 32'(ov()), 32'({6'b0, 7'b0010000}));

        // back-to-back ALU RAW
        cyc(); drv(1, 2, 3, 1, 0, 0, 0, 0);
        chk("raw_a", 32'(ov()), 32'h0);
        cyc(); drv(3, 4, 6, 1, 0, 0, 0, 0);
        chk("raw_b", 32'(ov()), 32'h0);
        cyc(); drv(3, 7, 8, 1, 0, 0, 0, 0);
        chk("raw_fwdM", 32'(ov()), 32'({2'b10, 2'b00, 1'b1, 1'b0, 7'b0}));
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_fwdW", 32'(ov()), 32'({2'b01, 2'b00, 1'b0, 1'b0, 7'b0}));
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_idle", 32'(ov()), 32'h0);

        // load-use
        cyc(); drv(1, 5, 5, 1, 1, 0, 0, 0);
        chk("lu_lw", 32'(ov()), 32'h0);
        cyc(); drv(6, 5, 7, 1, 0, 0, 0, 0);
        chk("lu_stall", 32'(ov()), 32'({6'b0, LDSTALL}));
        cyc(); drv(6, 5, 7, 1, 0, 0, 0, 0);
        chk("lu_once", 32'(ov()), 32'({5'b0, 1'b1, 7'b0}));
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwdBE", 32'(ov()), 32'({2'b00, 2'b01, 9'b0}));

        // writes to $0 are never forwarded or stalled on
        cyc(); drv(9, 10, 0, 1, 1, 0, 0, 0);
        chk("z_wr", 32'(ov()), 32'h0);
        cyc(); drv(0, 0, 11, 1, 0, 0, 0, 0);
        chk("z_nostall", 32'(ov()), 32'h0);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("z_noM", 32'(ov()), 32'h0);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("z_noW", 32'(ov()), 32'h0);

        // branch compare hazard, taken
        cyc(); drv(1, 1, 2, 1, 0, 0, 0, 0);
        chk("br_add", 32'(ov()), 32'h0);
        cyc(); drv(2, 4, 0, 0, 0, 1, 1, 0);
        chk("br_stall", 32'(ov()), 32'({6'b0, LDSTALL}));
        cyc(); drv(2, 4, 0, 0, 0, 1, 1, 0);
        chk("br_fwdAD", 32'(ov()), 32'({4'b0, 1'b1, 1'b0, 7'b0010000}));
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_after", 32'(ov()), 32'({2'b01, 11'b0}));

        // memory wait with a load in M
        cyc(); drv(3, 12, 12, 1, 1, 0, 0, 0);
        chk("mw_lw", 32'(ov()), 32'h0);
        cyc(); drv(13, 14, 15, 1, 0, 0, 0, 0);
        chk("mw_x", 32'(ov()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(); drv(15, 12, 16, 1, 0, 0, 0, 1);
            chk($sformatf("mw_busy%0d", i), 32'(ov()),
                32'({5'b0, 1'b1, MWAIT}));
        end
        cyc(); drv(15, 12, 16, 1, 0, 0, 0, 0);
        chk("mw_resume", 32'(ov()), 32'({5'b0, 1'b1, 7'b0}));
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_advance", 32'(ov()), 32'({2'b10, 2'b01, 9'b0}));

        // reset asserted during a load-use stall
        cyc(); drv(0, 0, 20, 1, 1, 0, 0, 0);
        chk("rl_lw", 32'(ov()), 32'h0);
        cyc(); drv(20, 0, 21, 1, 0, 0, 0, 0);
        chk("rl_stall", 32'(ov()), 32'({6'b0, LDSTALL}));
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_lw", lw_cnt, 32'd1);
        chk("cnt_br", br_cnt, 32'd1);
        chk("cnt_mw", mw_cnt, 32'd3);
`endif
        rst = 1'b1;
        #1;
        chk("rl_async", 32'(ov()), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_clr", lw_cnt | br_cnt | mw_cnt, 32'd0);
`endif
        cyc();
        rst = 1'b0;
        #1;
        chk("rl_first", 32'(ov()), 32'h0);
        cyc();
        chk("rl_nostall", 32'(ov()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
